// File: rtl/rob_queue_scheduler_pkg.sv
// Shared types and constants for the ROB queue scheduler.
// Contents: ROBQ_PAIR (entries moved per push/pop or written per cycle),
// the default widths and wb_req_t (writeback request payload).
package rob_queue_scheduler_pkg;

    localparam int unsigned ROBQ_PAIR       = 2;
    localparam int unsigned ROBQ_WIDTH      = 32;
    localparam int unsigned ROBQ_DEPTH_BITS = 4;

    // One writeback request as seen by the scheduler.
    typedef struct packed {
        logic                       valid;
        logic [ROBQ_DEPTH_BITS-1:0] idx;
        logic [ROBQ_WIDTH-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rob_queue_scheduler_arb.sv
// Round-robin dual arbiter: picks up to two requesters per cycle, scanning
// from rr_ptr. The second pick must target a different entry than the first.
// Ports: clk, rst (async, active-high); req/idx per requester in;
// slot0_oh/slot1_oh one-hot grants out (slot0 = first in scan order).
module rr_dual_arbiter #(
    parameter int unsigned NUM_WB = 4,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WB-1:0]             req,
    input  logic [NUM_WB-1:0][IDX_W-1:0]  idx,
    output logic [NUM_WB-1:0]             slot0_oh,
    output logic [NUM_WB-1:0]             slot1_oh
);

    localparam int unsigned PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pos;
    logic [PTR_W-1:0] last;
    logic [IDX_W-1:0] idx0;
    logic             have0;
    logic             have1;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_WB - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan all requesters once, starting at rr_ptr.
    always_comb begin
        slot0_oh = '0;
        slot1_oh = '0;
        pos      = rr_ptr;
        last     = rr_ptr;
        idx0     = '0;
        have0    = 1'b0;
        have1    = 1'b0;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (req[pos] && !have1) begin
                if (!have0) begin
                    slot0_oh[pos] = 1'b1;
                    have0         = 1'b1;
                    idx0          = idx[pos];
                    last          = pos;
                end else if (idx[pos] != idx0) begin
                    slot1_oh[pos] = 1'b1;
                    have1         = 1'b1;
                    last          = pos;
                end
            end
            pos = wrap_inc(pos);
        end
    end

    // Pointer moves just past the last granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (have0) begin
            rr_ptr <= wrap_inc(last);
        end
    end

endmodule

// File: rtl/rob_queue_scheduler.sv
// ROB queue scheduler: per cycle pushes a dispatch pair or pops a commit pair
// (never both), with starvation override for commit, and shares the queue's
// two in-place write ports among NUM_WB writeback units round-robin.
// Ports: disp_* (dispatch handshake), commit_* (retire handshake), wb_*
// (writeback requests/grants), q_* (queue strobes/status), occupancy.
// Optional: ROBQ_PERF_CNT_EN adds perf_push, perf_pop, perf_disp_stall,
// perf_wb_conflict 32-bit wrapping event counters.
module rob_queue_scheduler
    import rob_queue_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DEPTH_BITS   = 4,
    parameter int unsigned NUM_WB       = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 disp_req,
    input  logic [ROBQ_PAIR-1:0][WIDTH-1:0]      disp_data,
    output logic                                 disp_ack,
    input  logic                                 commit_req,
    output logic                                 commit_ack,
    input  logic [NUM_WB-1:0]                    wb_req,
    input  logic [NUM_WB-1:0][DEPTH_BITS-1:0]    wb_idx,
    input  logic [NUM_WB-1:0][WIDTH-1:0]         wb_data,
    output logic [NUM_WB-1:0]                    wb_grant,
    output logic                                 q_push,
    output logic                                 q_pop,
    output logic [ROBQ_PAIR-1:0][WIDTH-1:0]      q_in,
    output logic [ROBQ_PAIR-1:0][WIDTH-1:0]      q_reg_in,
    output logic [ROBQ_PAIR-1:0][DEPTH_BITS-1:0] q_reg_sel,
    output logic [ROBQ_PAIR-1:0]                 q_in_bitmask,
    input  logic                                 q_full,
    input  logic                                 q_empty,
    output logic [DEPTH_BITS:0]                  occupancy
`ifdef ROBQ_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_push,
    output logic [31:0]                          perf_pop,
    output logic [31:0]                          perf_disp_stall,
    output logic [31:0]                          perf_wb_conflict
`endif
);

    localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [DEPTH_BITS:0] OCC_MAX    = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] OCC_PAIR   = (DEPTH_BITS+1)'(ROBQ_PAIR);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [DEPTH_BITS-1:0] tail_ptr;
    logic [DEPTH_BITS-1:0] tail_ptr_p1;
    logic [DEPTH_BITS-1:0] tail_nxt;
    logic [DEPTH_BITS:0]   occ_nxt;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [STARVE_W-1:0]   starve_nxt;
    logic                  can_push;
    logic                  can_pop;
    logic                  do_push;
    logic                  do_pop;
    logic [NUM_WB-1:0]     wb_elig;
    logic [NUM_WB-1:0]     slot0_oh;
    logic [NUM_WB-1:0]     slot1_oh;

    assign tail_ptr_p1 = tail_ptr + DEPTH_BITS'(1);
    assign can_push    = (occupancy <= OCC_MAX - OCC_PAIR) && !q_full;
    assign can_pop     = (occupancy >= OCC_PAIR) && !q_empty;
    // Push has priority unless commit has waited STARVE_LIMIT cycles.
    assign do_pop  = !rst && commit_req && can_pop &&
                     (!(disp_req && can_push) || (starve_cnt == STARVE_MAX));
    assign do_push = !rst && disp_req && can_push && !do_pop;

    // Writes into the pair leaving this cycle are held off and retried.
    always_comb begin
        wb_elig = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            wb_elig[i] = !rst && wb_req[i] &&
                         !(do_pop && (wb_idx[i] == tail_ptr || wb_idx[i] == tail_ptr_p1));
        end
    end

    rr_dual_arbiter #(
        .NUM_WB (NUM_WB),
        .IDX_W  (DEPTH_BITS)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (wb_elig),
        .idx      (wb_idx),
        .slot0_oh (slot0_oh),
        .slot1_oh (slot1_oh)
    );

    // Same-cycle strobes to the queue and handshakes back to requesters.
    always_comb begin
        disp_ack     = do_push;
        commit_ack   = do_pop;
        q_push       = do_push;
        q_pop        = do_pop;
        q_in         = rst ? '0 : disp_data;
        wb_grant     = slot0_oh | slot1_oh;
        q_in_bitmask = {|slot1_oh, |slot0_oh};
        q_reg_in     = '0;
        q_reg_sel    = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (slot0_oh[i]) begin
                q_reg_in[0]  = wb_data[i];
                q_reg_sel[0] = wb_idx[i];
            end
            if (slot1_oh[i]) begin
                q_reg_in[1]  = wb_data[i];
                q_reg_sel[1] = wb_idx[i];
            end
        end
    end

    // Next occupancy, oldest-entry pointer and commit starvation count.
    always_comb begin
        occ_nxt    = occupancy;
        tail_nxt   = tail_ptr;
        starve_nxt = '0;
        if (do_push) begin
            occ_nxt = occupancy + OCC_PAIR;
        end
        if (do_pop) begin
            occ_nxt  = occupancy - OCC_PAIR;
            tail_nxt = tail_ptr + DEPTH_BITS'(ROBQ_PAIR);
        end
        if (commit_req && !do_pop) begin
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy  <= '0;
            tail_ptr   <= '0;
            starve_cnt <= '0;
        end else begin
            occupancy  <= occ_nxt;
            tail_ptr   <= tail_nxt;
            starve_cnt <= starve_nxt;
        end
    end

`ifdef ROBQ_PERF_CNT_EN
    // Event counters, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_push        <= '0;
            perf_pop         <= '0;
            perf_disp_stall  <= '0;
            perf_wb_conflict <= '0;
        end else begin
            if (do_push)                 perf_push        <= perf_push + 32'd1;
            if (do_pop)                  perf_pop         <= perf_pop + 32'd1;
            if (disp_req && !do_push)    perf_disp_stall  <= perf_disp_stall + 32'd1;
            if (|(wb_req & ~wb_grant))   perf_wb_conflict <= perf_wb_conflict + 32'd1;
        end
    end
`endif

    // Internal count must agree with the queue, and writebacks must target live entries.
    always @(posedge clk) begin
        if (!rst) begin
            assert (q_full == (occupancy == OCC_MAX));
            assert (q_empty == (occupancy == '0));
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_req[i]) begin
                    assert ({1'b0, DEPTH_BITS'(wb_idx[i] - tail_ptr)} < occupancy);
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_queue_scheduler.sv
// Testbench for rob_queue_scheduler: directed scenarios plus randomized
// traffic, checked every cycle against a queue-level reference model.
module tb_rob_queue_scheduler;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int DB     = 4;
    localparam int NUM_WB = 4;
    localparam int LIM    = 3;

    logic                       clk;
    logic                       rst;
    logic                       disp_req;
    logic [1:0][WIDTH-1:0]      disp_data;
    logic                       disp_ack;
    logic                       commit_req;
    logic                       commit_ack;
    logic [NUM_WB-1:0]          wb_req;
    logic [NUM_WB-1:0][DB-1:0]  wb_idx;
    logic [NUM_WB-1:0][WIDTH-1:0] wb_data;
    logic [NUM_WB-1:0]          wb_grant;
    logic                       q_push;
    logic                       q_pop;
    logic [1:0][WIDTH-1:0]      q_in;
    logic [1:0][WIDTH-1:0]      q_reg_in;
    logic [1:0][DB-1:0]         q_reg_sel;
    logic [1:0]                 q_in_bitmask;
    logic                       q_full;
    logic                       q_empty;
    logic [DB:0]                occupancy;

    rob_queue_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_BITS(DB), .NUM_WB(NUM_WB), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_data(disp_data), .disp_ack(disp_ack),
        .commit_req(commit_req), .commit_ack(commit_ack),
        .wb_req(wb_req), .wb_idx(wb_idx), .wb_data(wb_data), .wb_grant(wb_grant),
        .q_push(q_push), .q_pop(q_pop), .q_in(q_in), .q_reg_in(q_reg_in),
        .q_reg_sel(q_reg_sel), .q_in_bitmask(q_in_bitmask),
        .q_full(q_full), .q_empty(q_empty), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue as a count of live entries plus oldest index.
    int m_occ, m_tail, m_starve, m_rr, g_last;
    bit e_push, e_pop;
    logic [NUM_WB-1:0]     e_grant;
    logic [1:0]            e_mask;
    logic [1:0][WIDTH-1:0] e_reg_in;
    logic [1:0][DB-1:0]    e_sel;

    // Values seen in the most recent cycle, for directed checks.
    logic              last_disp_ack, last_commit_ack;
    logic [NUM_WB-1:0] last_grant;
    logic [1:0]        last_mask;
    logic [DB:0]       last_occ;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_tail = 0; m_starve = 0; m_rr = 0;
    endtask

    task automatic model_eval();
        bit push_ok, pop_ok;
        int g[$];
        int u, off;
        push_ok = disp_req && (m_occ + 2 <= DEPTH) && !q_full;
        pop_ok  = commit_req && (m_occ >= 2) && !q_empty;
        e_push = 0; e_pop = 0;
        if (push_ok && pop_ok) begin
            if (m_starve >= LIM) e_pop = 1; else e_push = 1;
        end else begin
            e_push = push_ok;
            e_pop  = pop_ok;
        end
        e_grant = '0; e_mask = '0; e_reg_in = '0; e_sel = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            u   = (m_rr + k) % NUM_WB;
            off = (int'(wb_idx[u]) - m_tail + DEPTH) % DEPTH;
            if (wb_req[u] && !(e_pop && off < 2) && g.size() < 2 &&
                (g.size() == 0 || wb_idx[g[0]] != wb_idx[u]))
                g.push_back(u);
        end
        foreach (g[s]) begin
            e_grant[g[s]] = 1'b1;
            e_mask[s]     = 1'b1;
            e_reg_in[s]   = wb_data[g[s]];
            e_sel[s]      = wb_idx[g[s]];
        end
        g_last = (g.size() > 0) ? g[g.size()-1] : -1;
    endtask

    task automatic model_update();
        if (e_push) m_occ += 2;
        if (e_pop) begin
            m_occ -= 2;
            m_tail = (m_tail + 2) % DEPTH;
        end
        if (commit_req && !e_pop) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else                      m_starve = 0;
        if (g_last >= 0) m_rr = (g_last + 1) % NUM_WB;
    endtask

    // One clock: present queue status, compare at negedge, advance model at posedge.
    task automatic cycle();
        q_full  = (m_occ == DEPTH);
        q_empty = (m_occ == 0);
        @(negedge clk);
        model_eval();
        check("disp_ack",   64'(disp_ack),     64'(e_push));
        check("q_push",     64'(q_push),       64'(e_push));
        check("commit_ack", 64'(commit_ack),   64'(e_pop));
        check("q_pop",      64'(q_pop),        64'(e_pop));
        check("q_in",       64'(q_in),         64'(disp_data));
        check("wb_grant",   64'(wb_grant),     64'(e_grant));
        check("bitmask",    64'(q_in_bitmask), 64'(e_mask));
        check("q_reg_in",   64'(q_reg_in),     64'(e_reg_in));
        check("q_reg_sel",  64'(q_reg_sel),    64'(e_sel));
        check("occupancy",  64'(occupancy),    64'(m_occ));
        last_disp_ack   = disp_ack;
        last_commit_ack = commit_ack;
        last_grant      = wb_grant;
        last_mask       = q_in_bitmask;
        last_occ        = occupancy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        disp_req   = 1'b0;
        commit_req = 1'b0;
        wb_req     = '0;
        wb_idx     = '0;
        wb_data    = '0;
        disp_data  = {$urandom, $urandom};
    endtask

    task automatic set_wb(input int u, input int idx);
        wb_req[u]  = 1'b1;
        wb_idx[u]  = DB'(idx);
        wb_data[u] = $urandom;
    endtask

    task automatic run_cycles(input bit d, input bit c, input int n);
        disp_req = d; commit_req = c;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        idle();
        disp_req = 1'b1;
        q_full = 1'b0; q_empty = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("rst_disp_ack",  64'(disp_ack),     64'd0);
        check("rst_q_in",      64'(q_in),         64'd0);
        check("rst_occupancy", 64'(occupancy),    64'd0);
        rst = 1'b0;
        idle();

        // Two units to the same entry: only the earlier in scan order wins.
        run_cycles(1, 0, 3);
        idle();
        set_wb(1, 5); set_wb(2, 5);
        cycle();
        check("same_idx_grant1", 64'(last_grant), 64'b0010);
        check("same_idx_mask1",  64'(last_mask),  64'b01);
        cycle();
        check("same_idx_grant2", 64'(last_grant), 64'b0100);

        // Reset mid-operation with occupancy 6.
        disp_req = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_disp_ack", 64'(disp_ack),     64'd0);
        check("midrst_grant",    64'(wb_grant),     64'd0);
        check("midrst_mask",     64'(q_in_bitmask), 64'd0);
        check("midrst_occ",      64'(occupancy),    64'd0);
        #2;
        rst = 1'b0;
        model_reset();
        idle();
        cycle();
        check("occ_after_reset", 64'(last_occ), 64'd0);

        // Four distinct writebacks rotate two at a time.
        run_cycles(1, 0, 2);
        idle();
        for (int u = 0; u < NUM_WB; u++) set_wb(u, u);
        cycle();
        check("rr_grant_a", 64'(last_grant), 64'b0011);
        check("rr_mask_a",  64'(last_mask),  64'b11);
        cycle();
        check("rr_grant_b", 64'(last_grant), 64'b1100);
        check("rr_mask_b",  64'(last_mask),  64'b11);
        cycle();
        check("rr_grant_c", 64'(last_grant), 64'b0011);

        // Writeback to an entry being popped is held off.
        idle();
        run_cycles(1, 0, 1);
        run_cycles(0, 1, 2);
        idle();
        commit_req = 1'b1;
        set_wb(0, 5);
        cycle();
        check("popblk_grant", 64'(last_grant),      64'd0);
        check("popblk_ack",   64'(last_commit_ack), 64'd1);
        idle();
        cycle();
        check("popblk_occ", 64'(last_occ), 64'd0);

        // Fill to full with dispatch only.
        acks = 0;
        disp_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (last_disp_ack) acks++;
        end
        check("fill_acks",     64'(acks),          64'd8);
        check("fill_stall",    64'(last_disp_ack), 64'd0);
        check("fill_occ_full", 64'(last_occ),      64'd16);

        // Drain to 8, then both requesting: commit wins every 4th cycle.
        run_cycles(0, 1, 4);
        disp_req = 1'b1; commit_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("starve_commit", 64'(last_commit_ack), 64'(i == 3));
            check("starve_disp",   64'(last_disp_ack),   64'(i != 3));
        end

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            disp_req   = ($urandom_range(0, 99) < 60);
            commit_req = ($urandom_range(0, 99) < 50);
            disp_data  = {$urandom, $urandom};
            wb_req     = '0;
            for (int u = 0; u < NUM_WB; u++) begin
                wb_idx[u]  = DB'($urandom);
                wb_data[u] = $urandom;
                if (m_occ > 0 && $urandom_range(0, 1) == 1)
                    set_wb(u, (m_tail + int'($urandom_range(0, m_occ - 1))) % DEPTH);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
